spi_xfer_ctrl: RTL and testbench
================================

// Module: spi_xfer_ctrl
// PURPOSE
//  Sequences one SPI mode-0 (CPOL=0, CPHA=0) full-duplex transfer of DATA_W bits per START request.
//  Runs entirely on CLK. Advances only on TICK_EN, the half-SCLK-period enable driven by CTRL_CLK from clock_domains.
//  Owns CS_N framing with programmable setup/hold, SCLK generation, MOSI shifting and MISO capture.
//  Presents a START/BUSY/DONE handshake to the upstream command logic.
// PARAMETERS
//  DATA_W    8  bits per transfer, MSB first; legal range 2..32
//  CS_SETUP  1  TICK_EN ticks from CS_N falling to first SCLK rise; legal range 1..15
//  CS_HOLD   1  TICK_EN ticks from last SCLK fall to CS_N rising; legal range 1..15
// PORTS
//  CLK      in   1       system clock; only clock in the block
//  NRST     in   1       synchronous reset, active low
//  TICK_EN  in   1       1-CLK enable pulse, one per SCLK half-period
//  START    in   1       transfer request; sampled only in IDLE
//  TX_DATA  in   DATA_W  word to send; latched on START acceptance
//  MISO     in   1       serial input from slave
//  BUSY     out  1       high from the cycle after acceptance until return to IDLE
//  DONE     out  1       1-CLK pulse; RX_DATA valid from this cycle on
//  RX_DATA  out  DATA_W  last received word; held until next DONE
//  SCLK     out  1       serial clock; idle low
//  MOSI     out  1       serial output; 0 while CS_N high
//  CS_N     out  1       slave select, active low
// BEHAVIOUR
//  Reset (NRST=0 at a CLK edge), from any state including mid-transfer:
//   - state=IDLE, BUSY=0, DONE=0, SCLK=0, MOSI=0, CS_N=1, RX_DATA=0
//   - shift registers and counters cleared; no partial RX_DATA update
//  All outputs are registered.
//  IDLE: START=1 on any CLK edge (TICK_EN not required) is accepted:
//   - tx_sr<=TX_DATA, CS_N<=0, MOSI<=TX_DATA[DATA_W-1], BUSY<=1
//   - setup count cleared; goto SETUP
//   - a TICK_EN coincident with acceptance is not counted
//  SETUP: count TICK_EN; on the CS_SETUP-th tick set SCLK<=1, sample MISO into rx_sr LSB; goto XFER.
//  XFER: every TICK_EN toggles SCLK.
//   - rising edge (SCLK 0->1): rx_sr<={rx_sr[DATA_W-2:0],MISO}; bit count +1
//   - falling edge (1->0) with bit count<DATA_W: shift tx_sr left; MOSI<=next bit
//   - falling edge with bit count==DATA_W: MOSI holds; goto HOLD
//   - exactly DATA_W rising edges per transfer
//  HOLD: count TICK_EN; on the CS_HOLD-th tick:
//   - CS_N<=1, MOSI<=0, RX_DATA<=rx_sr, DONE<=1, BUSY<=0; goto IDLE
//  Handshake and timing:
//   - DONE is high in the first IDLE cycle; a START in that same cycle is accepted (back-to-back transfers)
//   - START while BUSY=1 is ignored, not queued
//   - TX_DATA changes after acceptance do not affect the transfer
//  Transfer length = CS_SETUP + 2*DATA_W + CS_HOLD - 1 ticks from acceptance to DONE (CS_SETUP=1, DATA_W=8 -> 17 ticks).
//  No TICK_EN: the FSM stalls in its current state with all outputs frozen.
//  Counter widths: bit count ceil(log2(DATA_W+1)); setup/hold count 4 bits; no wrap inside legal range.
// TESTING
//  T1 TX_DATA=0xA5, MISO looped to MOSI, TICK_EN every 4 CLK -> RX_DATA=0xA5, DONE once after 17 ticks, MOSI bits 1,0,1,0,0,1,0,1 at SCLK rises.
//  T2 TX_DATA=0x3C, MISO tied 1 -> RX_DATA=0xFF, CS_N low for exactly 17 ticks, SCLK shows 8 rising edges, idles low.
//  T3 START pulsed again at ticks 3 and 10 of a transfer -> ignored: single DONE, BUSY continuous, no extra SCLK edges.
//  T4 NRST=0 at tick 6 of XFER with RX_DATA=0x5A from a prior transfer -> next cycle CS_N=1, SCLK=0, MOSI=0, BUSY=0, RX_DATA=0x00, no DONE.
//  T5 START held high through DONE, TICK_EN every cycle, TX 0x81 then 0x7E -> second transfer starts in the DONE cycle; RX 0x81 then 0x7E (loopback).
//  T6 CS_SETUP=3, CS_HOLD=2, TICK_EN gaps of 0..7 CLK (random) -> 3 ticks CS_N-to-first-SCLK, 2 ticks last-SCLK-fall-to-CS_N, 20 ticks total.

Source files
------------

// File: rtl/spi_xfer_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_xfer_ctrl_if
// Bundles the upstream command handshake and the SPI pins of spi_xfer_ctrl.
//   START    request a transfer (controller input)
//   TX_DATA  word to send, MSB first (controller input)
//   MISO     serial data from the slave (controller input)
//   BUSY     transfer in progress (controller output)
//   DONE     one-cycle completion pulse (controller output)
//   RX_DATA  last received word (controller output)
//   SCLK     serial clock, idle low (controller output)
//   MOSI     serial data to the slave (controller output)
//   CS_N     active-low slave select (controller output)
// modport slave  : the transfer controller itself
// modport master : the environment driving requests and the MISO line
// -----------------------------------------------------------------------------
interface spi_xfer_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              START;
    logic [DATA_W-1:0] TX_DATA;
    logic              MISO;
    logic              BUSY;
    logic              DONE;
    logic [DATA_W-1:0] RX_DATA;
    logic              SCLK;
    logic              MOSI;
    logic              CS_N;

    modport slave (
        input  START, TX_DATA, MISO,
        output BUSY, DONE, RX_DATA, SCLK, MOSI, CS_N
    );

    modport master (
        output START, TX_DATA, MISO,
        input  BUSY, DONE, RX_DATA, SCLK, MOSI, CS_N
    );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// spi_xfer_ctrl
// Sequences one SPI mode-0 (CPOL=0, CPHA=0) full-duplex transfer of DATA_W
// bits, MSB first, per accepted START. Everything runs on CLK and advances
// only on TICK_EN, a one-cycle enable marking each SCLK half-period.
// Ports:
//   CLK      system clock
//   NRST     synchronous reset, active low
//   TICK_EN  half-SCLK-period enable pulse
//   bus      spi_xfer_ctrl_if.slave: START/TX_DATA/MISO in,
//            BUSY/DONE/RX_DATA/SCLK/MOSI/CS_N out (all registered)
// Parameters:
//   DATA_W   bits per transfer (2..32)
//   CS_SETUP ticks from CS_N falling to the first SCLK rise (1..15)
//   CS_HOLD  ticks from the last SCLK fall to CS_N rising (1..15)
// -----------------------------------------------------------------------------
module spi_xfer_ctrl #(
    parameter int DATA_W   = 8,
    parameter int CS_SETUP = 1,
    parameter int CS_HOLD  = 1
) (
    input  logic           CLK,
    input  logic           NRST,
    input  logic           TICK_EN,
    spi_xfer_ctrl_if.slave bus
);

    localparam int BCW = $clog2(DATA_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    // Terminal values of the phase counters, pre-sized to the counter widths.
    localparam logic [3:0]     SETUP_LAST = 4'(CS_SETUP - 1);
    localparam logic [3:0]     HOLD_LAST  = 4'(CS_HOLD - 1);
    localparam logic [BCW-1:0] BCNT_FULL  = BCW'(DATA_W);
    localparam logic [BCW-1:0] BCNT_ONE   = BCW'(1);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [BCW-1:0]    bcnt_q,  bcnt_d;
    logic [3:0]        tcnt_q,  tcnt_d;
    logic              sclk_q,  sclk_d;
    logic              mosi_q,  mosi_d;
    logic              csn_q,   csn_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic [DATA_W-1:0] rxd_q,   rxd_d;

    always_comb begin
        state_d = state_q;
        tx_sr_d = tx_sr_q;
        rx_sr_d = rx_sr_q;
        bcnt_d  = bcnt_q;
        tcnt_d  = tcnt_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        csn_d   = csn_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rxd_d   = rxd_q;

        case (state_q)
            S_IDLE: begin
                // Acceptance does not wait for TICK_EN, and a tick landing
                // on this edge is not counted toward setup.
                if (bus.START) begin
                    tx_sr_d = bus.TX_DATA;
                    rx_sr_d = '0;
                    mosi_d  = bus.TX_DATA[DATA_W-1];
                    csn_d   = 1'b0;
                    busy_d  = 1'b1;
                    tcnt_d  = '0;
                    bcnt_d  = '0;
                    state_d = S_SETUP;
                end
            end

            S_SETUP: begin
                if (TICK_EN) begin
                    if (tcnt_q == SETUP_LAST) begin
                        // Last setup tick is also the first SCLK rise.
                        sclk_d  = 1'b1;
                        rx_sr_d = {rx_sr_q[DATA_W-2:0], bus.MISO};
                        bcnt_d  = BCNT_ONE;
                        state_d = S_XFER;
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end

            S_XFER: begin
                if (TICK_EN) begin
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        rx_sr_d = {rx_sr_q[DATA_W-2:0], bus.MISO};
                        bcnt_d  = bcnt_q + BCNT_ONE;
                    end else begin
                        sclk_d = 1'b0;
                        if (bcnt_q == BCNT_FULL) begin
                            // Final fall: MOSI keeps the LSB through hold.
                            tcnt_d  = '0;
                            state_d = S_HOLD;
                        end else begin
                            tx_sr_d = tx_sr_q << 1;
                            mosi_d  = tx_sr_q[DATA_W-2];
                        end
                    end
                end
            end

            S_HOLD: begin
                if (TICK_EN) begin
                    if (tcnt_q == HOLD_LAST) begin
                        csn_d   = 1'b1;
                        mosi_d  = 1'b0;
                        rxd_d   = rx_sr_q;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state_q <= S_IDLE;
            tx_sr_q <= '0;
            rx_sr_q <= '0;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            csn_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rxd_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_sr_q <= tx_sr_d;
            rx_sr_q <= rx_sr_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            csn_q   <= csn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rxd_q   <= rxd_d;
        end
    end

    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.RX_DATA = rxd_q;
    assign bus.SCLK    = sclk_q;
    assign bus.MOSI    = mosi_q;
    assign bus.CS_N    = csn_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_xfer_ctrl
// Two controllers: dut0 (CS_SETUP=1, CS_HOLD=1) and dut1 (CS_SETUP=3,
// CS_HOLD=2), both DATA_W=8. sel picks which one the stimulus drives and
// which one the m_* observation wires show. Inputs change and outputs are
// sampled on the falling CLK edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_xfer_ctrl;
    localparam int W = 8;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic         NRST;
    logic         sel;
    logic         start;
    logic         tick;
    logic         loop;
    logic         miso;
    logic [W-1:0] tx;
    logic         tick0, tick1;

    spi_xfer_ctrl_if #(.DATA_W(W)) b0 ();
    spi_xfer_ctrl_if #(.DATA_W(W)) b1 ();

    assign tick0      = tick & ~sel;
    assign tick1      = tick & sel;
    assign b0.START   = start & ~sel;
    assign b1.START   = start & sel;
    assign b0.TX_DATA = tx;
    assign b1.TX_DATA = tx;
    assign b0.MISO    = loop ? b0.MOSI : miso;
    assign b1.MISO    = loop ? b1.MOSI : miso;

    spi_xfer_ctrl #(.DATA_W(W), .CS_SETUP(1), .CS_HOLD(1)) dut0 (
        .CLK(CLK), .NRST(NRST), .TICK_EN(tick0), .bus(b0.slave)
    );
    spi_xfer_ctrl #(.DATA_W(W), .CS_SETUP(3), .CS_HOLD(2)) dut1 (
        .CLK(CLK), .NRST(NRST), .TICK_EN(tick1), .bus(b1.slave)
    );

    logic         m_busy, m_done, m_sclk, m_mosi, m_csn;
    logic [W-1:0] m_rx;
    assign m_busy = sel ? b1.BUSY    : b0.BUSY;
    assign m_done = sel ? b1.DONE    : b0.DONE;
    assign m_sclk = sel ? b1.SCLK    : b0.SCLK;
    assign m_mosi = sel ? b1.MOSI    : b0.MOSI;
    assign m_csn  = sel ? b1.CS_N    : b0.CS_N;
    assign m_rx   = sel ? b1.RX_DATA : b0.RX_DATA;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int setup_ticks();
        return sel ? 3 : 1;
    endfunction

    function automatic int hold_ticks();
        return sel ? 2 : 1;
    endfunction

    // mode: 0 loopback, 1 MISO tied 1, 2 MISO tied 0, 3 random MISO.
    // Gaps between ticks are drawn from [gmin,gmax] idle cycles.
    // poke re-asserts START at the 3rd and 10th ticks of the transfer.
    // Returns RX_DATA seen with DONE and the MISO bits present at each SCLK rise.
    task automatic run_xfer(input logic [W-1:0] txw, input int mode, input int gmin,
                            input int gmax, input bit poke,
                            output logic [W-1:0] rxw, output logic [W-1:0] miso_bits);
        int           ticks = 0, rises = 0, dones = 0, gap;
        int           first_rise = -1, last_fall = -1, cyc;
        logic [W-1:0] mosi_bits = '0;
        logic         prev_sclk = 1'b0, tick_prev, miso_prev;
        bit           busy_broken = 1'b0;
        string        tag;
        tag = $sformatf("x%0h_s%0d", txw, sel);
        miso_bits = '0;
        @(negedge CLK);
        loop  = (mode == 0);
        miso  = (mode == 3) ? 1'($urandom_range(1, 0)) : (mode == 1);
        tx    = txw;
        start = 1'b1;
        tick  = 1'b1;                      // coincides with acceptance
        gap   = $urandom_range(gmax, gmin);
        tick_prev = tick;
        miso_prev = miso;
        for (cyc = 0; cyc < 3000 && dones == 0; cyc++) begin
            @(negedge CLK);
            if (cyc == 0) begin
                chk({"accept_", tag}, {m_busy, m_csn}, 2'b10);
                tx = ~txw;                 // later TX_DATA changes must not matter
            end else if (tick_prev) begin
                ticks++;
            end
            if (!prev_sclk && m_sclk) begin
                rises++;
                mosi_bits = {mosi_bits[W-2:0], m_mosi};
                miso_bits = {miso_bits[W-2:0], miso_prev};
                if (first_rise < 0) first_rise = ticks;
            end
            if (prev_sclk && !m_sclk) last_fall = ticks;
            if (m_done) dones++;
            else if (!m_busy) busy_broken = 1'b1;
            prev_sclk = m_sclk;
            start = poke && tick_prev && cyc > 0 && (ticks == 3 || ticks == 10);
            if (mode == 3) miso = 1'($urandom_range(1, 0));
            if (gap == 0) begin
                tick = 1'b1;
                gap  = $urandom_range(gmax, gmin);
            end else begin
                tick = 1'b0;
                gap--;
            end
            tick_prev = tick;
            miso_prev = miso;
        end
        start = 1'b0;
        tick  = 1'b0;
        chk({"done_once_", tag}, dones, 1);
        chk({"len_", tag}, ticks, setup_ticks() + 2 * W + hold_ticks() - 1);
        chk({"rises_", tag}, rises, W);
        chk({"setup_", tag}, first_rise, setup_ticks());
        chk({"hold_", tag}, ticks - last_fall, hold_ticks());
        chk({"mosi_bits_", tag}, mosi_bits, txw);
        chk({"busy_cont_", tag}, busy_broken, 0);
        chk({"idle_pins_", tag}, {m_busy, m_csn, m_sclk, m_mosi}, 4'b0100);
        rxw = m_rx;
    endtask

    typedef struct {
        logic [W-1:0] tx;
        int           mode;
        int           gmin;
        int           gmax;
        bit           sel;
        bit           poke;
        logic [W-1:0] exp_rx;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r, e;
        logic [12:0]  snap;
        bit           bad;
        int           n, k;

        vecs[0] = '{8'hA5, 0, 3, 3, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{8'h3C, 1, 1, 1, 1'b0, 1'b0, 8'hFF};
        vecs[2] = '{8'hC3, 0, 2, 2, 1'b0, 1'b1, 8'hC3};
        vecs[3] = '{8'h00, 1, 0, 0, 1'b0, 1'b0, 8'hFF};
        vecs[4] = '{8'hFF, 2, 0, 2, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{8'h96, 0, 0, 7, 1'b1, 1'b0, 8'h96};
        vecs[6] = '{8'h3C, 1, 0, 7, 1'b1, 1'b0, 8'hFF};

        NRST = 1'b0; sel = 1'b0; start = 1'b0; tick = 1'b1;
        loop = 1'b0; miso = 1'b1; tx = 8'hFF;
        repeat (3) @(negedge CLK);
        chk("rst_dut0", {b0.BUSY, b0.DONE, b0.SCLK, b0.MOSI, b0.CS_N, b0.RX_DATA}, 13'h0100);
        chk("rst_dut1", {b1.BUSY, b1.DONE, b1.SCLK, b1.MOSI, b1.CS_N, b1.RX_DATA}, 13'h0100);
        NRST = 1'b1; tick = 1'b0;

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            sel = vecs[i].sel;
            run_xfer(vecs[i].tx, vecs[i].mode, vecs[i].gmin, vecs[i].gmax, vecs[i].poke, r, e);
            chk($sformatf("vec%0d_rx", i), r, vecs[i].exp_rx);
        end

        // Random MISO: expected word is the MISO bits at the SCLK rises, MSB first
        for (int i = 0; i < 12; i++) begin
            sel = 1'($urandom_range(1, 0));
            run_xfer(W'($urandom), 3, 0, $urandom_range(3, 0), 1'b0, r, e);
            chk($sformatf("rand%0d_rx", i), r, e);
        end

        // Back-to-back: START held through DONE, tick every cycle
        sel = 1'b0; loop = 1'b1;
        @(negedge CLK); tx = 8'h81; start = 1'b1; tick = 1'b1;
        @(negedge CLK); chk("b2b_busy1", m_busy, 1); tx = 8'h7E;
        n = 0;
        while (!m_done && n < 200) begin @(negedge CLK); n++; end
        chk("b2b_len1", n, 17);
        chk("b2b_rx1", m_rx, 8'h81);
        @(negedge CLK);
        chk("b2b_restart", {m_busy, m_csn, m_done}, 3'b100);
        start = 1'b0;
        n = 0;
        while (!m_done && n < 200) begin @(negedge CLK); n++; end
        chk("b2b_len2", n, 17);
        chk("b2b_rx2", m_rx, 8'h7E);
        tick = 1'b0;

        // Stall: no TICK_EN freezes every output
        @(negedge CLK); tx = 8'hD2; start = 1'b1;
        @(negedge CLK); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1; @(negedge CLK); tick = 1'b0; @(negedge CLK);
        end
        snap = {m_busy, m_done, m_sclk, m_mosi, m_csn, m_rx};
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if ({m_busy, m_done, m_sclk, m_mosi, m_csn, m_rx} !== snap) bad = 1'b1;
        end
        chk("stall_frozen", bad, 0);
        tick = 1'b1; n = 0;
        while (!m_done && n < 200) begin @(negedge CLK); n++; end
        chk("stall_len_rest", n, 12);
        chk("stall_rx", m_rx, 8'hD2);
        tick = 1'b0;

        // Reset in the middle of XFER, after a 0x5A transfer
        run_xfer(8'h5A, 0, 1, 1, 1'b0, r, e);
        chk("rstmid_pre_rx", r, 8'h5A);
        @(negedge CLK); start = 1'b1; tick = 1'b0;
        n = 0; k = 0;
        while (k < 7 && n < 500) begin
            @(negedge CLK);
            start = 1'b0;
            if (tick) k++;
            tick = ~tick;
            n++;
        end
        chk("rstmid_in_xfer", {m_busy, m_csn}, 2'b10);
        NRST = 1'b0;
        @(negedge CLK);
        chk("rstmid_pins", {m_busy, m_done, m_sclk, m_mosi, m_csn}, 5'b00001);
        chk("rstmid_rx", m_rx, 8'h00);
        NRST = 1'b1; tick = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (m_done || m_busy || !m_csn || m_sclk) bad = 1'b1;
        end
        chk("rstmid_quiet", bad, 0);
        tick = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
